// File: rtl/sc_mux21_arbiter_if.sv
// sc_mux21_arbiter_if: requester/consumer handshake bundle for the 2:1 mux arbiter.
// The master modport is the environment side (requesters and consumer); the
// slave modport is the arbiter side.
interface sc_mux21_arbiter_if #(
    parameter int NUMBER_DATAWIDTH = 8
);
    logic                        SC_MUX21ARB_req0Valid_In;
    logic [NUMBER_DATAWIDTH-1:0] SC_MUX21ARB_data0_InBUS;
    logic                        SC_MUX21ARB_req0Ready_Out;
    logic                        SC_MUX21ARB_req1Valid_In;
    logic [NUMBER_DATAWIDTH-1:0] SC_MUX21ARB_data1_InBUS;
    logic                        SC_MUX21ARB_req1Ready_Out;
    logic                        SC_MUX21ARB_outValid_Out;
    logic [NUMBER_DATAWIDTH-1:0] SC_MUX21ARB_z_OutBUS;
    logic                        SC_MUX21ARB_outReady_In;
    logic                        SC_MUX21ARB_select_Out;

    modport master (
        output SC_MUX21ARB_req0Valid_In, SC_MUX21ARB_data0_InBUS,
        output SC_MUX21ARB_req1Valid_In, SC_MUX21ARB_data1_InBUS,
        output SC_MUX21ARB_outReady_In,
        input  SC_MUX21ARB_req0Ready_Out, SC_MUX21ARB_req1Ready_Out,
        input  SC_MUX21ARB_outValid_Out, SC_MUX21ARB_z_OutBUS,
        input  SC_MUX21ARB_select_Out
    );

    modport slave (
        input  SC_MUX21ARB_req0Valid_In, SC_MUX21ARB_data0_InBUS,
        input  SC_MUX21ARB_req1Valid_In, SC_MUX21ARB_data1_InBUS,
        input  SC_MUX21ARB_outReady_In,
        output SC_MUX21ARB_req0Ready_Out, SC_MUX21ARB_req1Ready_Out,
        output SC_MUX21ARB_outValid_Out, SC_MUX21ARB_z_OutBUS,
        output SC_MUX21ARB_select_Out
    );
endinterface

// File: rtl/sc_mux21_arbiter.sv
// sc_mux21_arbiter: two-requester arbiter with one-entry output register that
// owns the 2:1 mux select line.
// Optional feature: define SC_MUX21ARB_RR_EN for round-robin arbitration;
// without it requester 0 has fixed priority and the last-grant pointer is absent.
//
// state | meaning
// EMPTY | output register holds no word
// FULL  | output register holds a word awaiting the consumer
module sc_mux21_arbiter #(
    parameter int NUMBER_DATAWIDTH = 8
) (
    input  logic                SC_MUX21ARB_CLOCK_50,
    input  logic                SC_MUX21ARB_RESET_InLow,
    sc_mux21_arbiter_if.slave   bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                      state_q, state_d;
    logic [NUMBER_DATAWIDTH-1:0] z_q, z_d;
    logic                        sel_q, sel_d;
    logic                        grant;
    logic                        accept;
    logic                        rdy0, rdy1;
    logic                        xfer;

`ifdef SC_MUX21ARB_RR_EN
    logic last_q, last_d;

    // Round-robin: on contention the requester that did not win last time goes.
    always_comb begin
        grant = 1'b0;
        if (bus.SC_MUX21ARB_req0Valid_In && bus.SC_MUX21ARB_req1Valid_In)
            grant = ~last_q;
        else
            grant = bus.SC_MUX21ARB_req1Valid_In;
    end
`else
    // Fixed priority: requester 1 only wins when requester 0 is idle.
    always_comb begin
        grant = ~bus.SC_MUX21ARB_req0Valid_In & bus.SC_MUX21ARB_req1Valid_In;
    end
`endif

    // Handshake decode and next-state/output-register computation.
    always_comb begin
        state_d = state_q;
        z_d     = z_q;
        sel_d   = sel_q;
`ifdef SC_MUX21ARB_RR_EN
        last_d  = last_q;
`endif
        accept  = (state_q == EMPTY) | bus.SC_MUX21ARB_outReady_In;
        // Readys are suppressed during reset so no word is taken and then discarded.
        rdy0    = SC_MUX21ARB_RESET_InLow & accept & ~grant & bus.SC_MUX21ARB_req0Valid_In;
        rdy1    = SC_MUX21ARB_RESET_InLow & accept &  grant & bus.SC_MUX21ARB_req1Valid_In;
        xfer    = rdy0 | rdy1;
        if (xfer) begin
            state_d = FULL;
            z_d     = grant ? bus.SC_MUX21ARB_data1_InBUS : bus.SC_MUX21ARB_data0_InBUS;
            sel_d   = grant;
`ifdef SC_MUX21ARB_RR_EN
            last_d  = grant;
`endif
        end else if ((state_q == FULL) && bus.SC_MUX21ARB_outReady_In) begin
            state_d = EMPTY;
        end
    end

    // State and output register with synchronous active-low reset.
    always_ff @(posedge SC_MUX21ARB_CLOCK_50) begin
        if (!SC_MUX21ARB_RESET_InLow) begin
            state_q <= EMPTY;
            z_q     <= '0;
            sel_q   <= 1'b0;
`ifdef SC_MUX21ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            sel_q   <= sel_d;
`ifdef SC_MUX21ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign bus.SC_MUX21ARB_req0Ready_Out = rdy0;
    assign bus.SC_MUX21ARB_req1Ready_Out = rdy1;
    assign bus.SC_MUX21ARB_outValid_Out  = (state_q == FULL);
    assign bus.SC_MUX21ARB_z_OutBUS      = z_q;
    assign bus.SC_MUX21ARB_select_Out    = sel_q;
endmodule

// File: tb/tb_sc_mux21_arbiter.sv
// tb_sc_mux21_arbiter: directed stimulus with a cycle-level reference model
// and literal checkpoints for sc_mux21_arbiter.
module tb_sc_mux21_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    sc_mux21_arbiter_if #(.NUMBER_DATAWIDTH(8)) bus ();

    sc_mux21_arbiter #(.NUMBER_DATAWIDTH(8)) dut (
        .SC_MUX21ARB_CLOCK_50    (clk),
        .SC_MUX21ARB_RESET_InLow (rst_n),
        .bus                     (bus.slave)
    );

    always #5 clk = ~clk;

`ifdef SC_MUX21ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the output register holds, who went last.
    bit       m_full = 1'b0;
    bit [7:0] m_z    = 8'h00;
    bit       m_sel  = 1'b0;
    bit       m_last = 1'b1;

    function automatic int pick_winner(bit v0, bit v1, bit last);
        if (v0 && v1) return (RR && last == 1'b0) ? 1 : 0;
        if (v1) return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        bit v0, v1, room, e0, e1;
        int w;
        v0   = bus.SC_MUX21ARB_req0Valid_In;
        v1   = bus.SC_MUX21ARB_req1Valid_In;
        room = !m_full || bus.SC_MUX21ARB_outReady_In;
        w    = pick_winner(v0, v1, m_last);
        e0   = rst_n && room && v0 && (w == 0);
        e1   = rst_n && room && v1 && (w == 1);
        chk("m_rdy0",  bus.SC_MUX21ARB_req0Ready_Out, e0);
        chk("m_rdy1",  bus.SC_MUX21ARB_req1Ready_Out, e1);
        chk("m_valid", bus.SC_MUX21ARB_outValid_Out,  m_full);
        chk("m_z",     bus.SC_MUX21ARB_z_OutBUS,      m_z);
        chk("m_sel",   bus.SC_MUX21ARB_select_Out,    m_sel);
        if (!rst_n) begin
            m_full = 0; m_z = 8'h00; m_sel = 0; m_last = 1;
        end else if (e0 || e1) begin
            m_full = 1;
            m_z    = e1 ? bus.SC_MUX21ARB_data1_InBUS : bus.SC_MUX21ARB_data0_InBUS;
            m_sel  = e1;
            m_last = e1;
        end else if (m_full && bus.SC_MUX21ARB_outReady_In) begin
            m_full = 0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v0, input logic [7:0] d0, input bit v1,
                          input logic [7:0] d1, input bit ordy);
        bus.SC_MUX21ARB_req0Valid_In = v0;
        bus.SC_MUX21ARB_data0_InBUS  = d0;
        bus.SC_MUX21ARB_req1Valid_In = v1;
        bus.SC_MUX21ARB_data1_InBUS  = d1;
        bus.SC_MUX21ARB_outReady_In  = ordy;
    endtask

    initial begin
        logic [7:0] contention_seq [4];
        logic [7:0] bp_next;
        bit         bp_sel;
        if (RR) begin
            contention_seq = '{8'h11, 8'h22, 8'h11, 8'h22};
            bp_next = 8'h66; bp_sel = 1'b1;
        end else begin
            contention_seq = '{8'h11, 8'h11, 8'h11, 8'h11};
            bp_next = 8'h55; bp_sel = 1'b0;
        end

        // Reset held for two cycles with both requesters valid.
        set_in(1, 8'h11, 1, 8'h22, 1);
        for (int i = 0; i < 2; i++) begin
            cyc(); #1;
            chk("rst_rdy0",  bus.SC_MUX21ARB_req0Ready_Out, 0);
            chk("rst_rdy1",  bus.SC_MUX21ARB_req1Ready_Out, 0);
            chk("rst_valid", bus.SC_MUX21ARB_outValid_Out, 0);
            chk("rst_z",     bus.SC_MUX21ARB_z_OutBUS, 8'h00);
            chk("rst_sel",   bus.SC_MUX21ARB_select_Out, 0);
        end

        // Release: requester 0 wins the first contention.
        cyc(); rst_n = 1'b1; #1;
        chk("first_rdy0", bus.SC_MUX21ARB_req0Ready_Out, 1);
        chk("first_rdy1", bus.SC_MUX21ARB_req1Ready_Out, 0);

        // Contention with the consumer always ready.
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            chk("cont_z",     bus.SC_MUX21ARB_z_OutBUS, contention_seq[i]);
            chk("cont_model", m_z, contention_seq[i]);
            chk("cont_valid", bus.SC_MUX21ARB_outValid_Out, 1);
            if (!RR) chk("cont_rdy1", bus.SC_MUX21ARB_req1Ready_Out, 0);
        end

        // Single requester 1 with 0xA5.
        cyc(); set_in(0, 8'h00, 1, 8'hA5, 1); #1;
        chk("single_rdy1", bus.SC_MUX21ARB_req1Ready_Out, 1);
        cyc(); set_in(1, 8'h3C, 0, 8'h00, 1); #1;
        chk("single_z",     bus.SC_MUX21ARB_z_OutBUS, 8'hA5);
        chk("single_sel",   bus.SC_MUX21ARB_select_Out, 1);
        chk("single_valid", bus.SC_MUX21ARB_outValid_Out, 1);
        chk("load3c_rdy0",  bus.SC_MUX21ARB_req0Ready_Out, 1);

        // Backpressure: 0x3C held for five stalled cycles with both valid.
        cyc(); set_in(1, 8'h55, 1, 8'h66, 0); #1;
        chk("bp_model", m_z, 8'h3C);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin cyc(); #1; end
            chk("bp_rdy0",  bus.SC_MUX21ARB_req0Ready_Out, 0);
            chk("bp_rdy1",  bus.SC_MUX21ARB_req1Ready_Out, 0);
            chk("bp_z",     bus.SC_MUX21ARB_z_OutBUS, 8'h3C);
            chk("bp_sel",   bus.SC_MUX21ARB_select_Out, 0);
            chk("bp_valid", bus.SC_MUX21ARB_outValid_Out, 1);
        end
        cyc(); bus.SC_MUX21ARB_outReady_In = 1'b1; #1;
        chk("bp_release_rdy1", bus.SC_MUX21ARB_req1Ready_Out, bp_sel);
        chk("bp_release_rdy0", bus.SC_MUX21ARB_req0Ready_Out, !bp_sel);
        cyc(); set_in(0, 8'h00, 0, 8'h00, 1); #1;
        chk("bp_next_z",     bus.SC_MUX21ARB_z_OutBUS, bp_next);
        chk("bp_next_sel",   bus.SC_MUX21ARB_select_Out, bp_sel);
        chk("bp_next_valid", bus.SC_MUX21ARB_outValid_Out, 1);

        // Drain: no requests, consumer ready.
        cyc(); #1;
        chk("drain_valid", bus.SC_MUX21ARB_outValid_Out, 0);
        chk("drain_z",     bus.SC_MUX21ARB_z_OutBUS, bp_next);
        chk("drain_sel",   bus.SC_MUX21ARB_select_Out, bp_sel);

        // Reset while FULL and stalled discards the stored word.
        set_in(1, 8'h77, 0, 8'h00, 1);
        cyc(); set_in(0, 8'h00, 0, 8'h00, 0); #1;
        chk("mid_z", bus.SC_MUX21ARB_z_OutBUS, 8'h77);
        cyc(); rst_n = 1'b0; #1;
        chk("mid_hold_valid", bus.SC_MUX21ARB_outValid_Out, 1);
        cyc(); rst_n = 1'b1; bus.SC_MUX21ARB_outReady_In = 1'b1; #1;
        chk("mid_rst_valid", bus.SC_MUX21ARB_outValid_Out, 0);
        chk("mid_rst_z",     bus.SC_MUX21ARB_z_OutBUS, 8'h00);
        chk("mid_rst_sel",   bus.SC_MUX21ARB_select_Out, 0);
        cyc(); #1;
        chk("mid_after_valid", bus.SC_MUX21ARB_outValid_Out, 0);

        // Short mixed tail for the per-cycle model.
        set_in(1, 8'h81, 1, 8'h92, 1);
        cyc(); cyc();
        bus.SC_MUX21ARB_outReady_In = 1'b0;
        cyc(); cyc();
        set_in(0, 8'h00, 1, 8'hB3, 1);
        cyc(); cyc();
        set_in(0, 8'h00, 0, 8'h00, 1);
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
